// File: rtl/fsm_01.sv
// Debounced 2:1 mux select controller: a request must be held alone for
// STABLE_CYCLES consecutive edges before select flips. Optional FSM_01_STATE_OUT_EN exposes state_o/arming.
module fsm_01 #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       a,
  input  logic       b,
`ifdef FSM_01_STATE_OUT_EN
  output logic [1:0] state_o,
  output logic       arming,
`endif
  output logic       select
);

  // Encoding chosen so select is state bit 1 and arming is the XOR of the bits.
  typedef enum logic [1:0] {
    SEL_A = 2'b00,
    ARM_B = 2'b01,
    SEL_B = 2'b11,
    ARM_A = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES);
  localparam bit               SINGLE      = (STABLE_CYCLES == 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             req_a;
  logic             req_b;

  // A tie (both or neither asserted) is never a request.
  assign req_a   = a & ~b;
  assign req_b   = b & ~a;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q <= SEL_A;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SEL_A: begin
          cnt_q <= '0;
          if (req_b) begin
            if (SINGLE) begin
              state_q <= SEL_B;
            end else begin
              state_q <= ARM_B;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        ARM_B: begin
          if (req_b) begin
            if (cnt_inc == STABLE_LAST) begin
              state_q <= SEL_B;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            state_q <= SEL_A;
            cnt_q   <= '0;
          end
        end
        SEL_B: begin
          cnt_q <= '0;
          if (req_a) begin
            if (SINGLE) begin
              state_q <= SEL_A;
            end else begin
              state_q <= ARM_A;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        ARM_A: begin
          if (req_a) begin
            if (cnt_inc == STABLE_LAST) begin
              state_q <= SEL_A;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            state_q <= SEL_B;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= SEL_A;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign select = state_q[1];

`ifdef FSM_01_STATE_OUT_EN
  assign state_o = state_q;
  assign arming  = state_q[1] ^ state_q[0];
`endif

endmodule

// File: tb/tb_fsm_01.sv
// Directed self-checking bench for fsm_01 with STABLE_CYCLES=2 and =1 instances.
module tb_fsm_01;

  logic clk;
  logic rstN;
  logic a, b;
  logic a1, b1;
  logic sel2, sel1;
`ifdef FSM_01_STATE_OUT_EN
  logic [1:0] st2, st1;
  logic       arm2, arm1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fsm_01 #(.STABLE_CYCLES(2), .CNT_W(8)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .a      (a),
    .b      (b),
`ifdef FSM_01_STATE_OUT_EN
    .state_o(st2),
    .arming (arm2),
`endif
    .select (sel2)
  );

  fsm_01 #(.STABLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk    (clk),
    .rstN   (rstN),
    .a      (a1),
    .b      (b1),
`ifdef FSM_01_STATE_OUT_EN
    .state_o(st1),
    .arming (arm1),
`endif
    .select (sel1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check select of the STABLE_CYCLES=2 instance and, when exposed, its state.
  task automatic chk2(input string tag, input int exp_sel, input int exp_st);
    check_eq({tag, "_sel"}, int'(sel2), exp_sel);
`ifdef FSM_01_STATE_OUT_EN
    check_eq({tag, "_st"}, int'(st2), exp_st);
    check_eq({tag, "_arm"}, int'(arm2), (exp_st == 1 || exp_st == 2) ? 1 : 0);
`else
    if (exp_st < 0) $display("bad expected state for %s", tag);
`endif
  endtask

  initial begin
    rstN = 1'b1; a = 1'b1; b = 1'b1; a1 = 1'b0; b1 = 1'b0;

    // Reset held two clocks with a=b=1
    tick(); chk2("rst1", 0, 0);
    check_eq("rst1_sel1", int'(sel1), 0);
    tick(); chk2("rst2", 0, 0);
    rstN = 1'b0; a = 1'b0; b = 1'b0;
    tick(); chk2("idle0", 0, 0);
    tick(); chk2("idle1", 0, 0);

    // Switch to B in two edges, then hold
    b = 1'b1;
    tick(); chk2("armb", 0, 1);
    tick(); chk2("selb", 1, 3);
    for (int i = 0; i < 5; i++) begin
      tick(); chk2("holdb", 1, 3);
    end

    // Tie keeps B, then a alone returns to A after two edges
    a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk2("tie", 1, 3);
    end
    b = 1'b0;
    tick(); chk2("arma", 1, 2);
    tick(); chk2("sela", 0, 0);

    // One-clock glitch on b is rejected
    a = 1'b0; b = 1'b1;
    tick(); chk2("glb_arm", 0, 1);
    b = 1'b0;
    tick(); chk2("glb_back", 0, 0);
    tick(); chk2("glb_stay", 0, 0);

    // Request for the current input is ignored
    a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk2("ignore_a", 0, 0);
    end

    // Reset during qualification forces full requalification
    a = 1'b0; b = 1'b1;
    tick(); chk2("rq_arm", 0, 1);
    rstN = 1'b1;
    tick(); chk2("rq_rst", 0, 0);
    rstN = 1'b0;
    tick(); chk2("rq_arm2", 0, 1);
    tick(); chk2("rq_selb", 1, 3);

    // Glitch on a from SEL_B is rejected, then a real request lands
    a = 1'b1; b = 1'b0;
    tick(); chk2("gla_arm", 1, 2);
    a = 1'b0;
    tick(); chk2("gla_back", 1, 3);
    a = 1'b1;
    tick(); chk2("gla_arm2", 1, 2);
    tick(); chk2("gla_sela", 0, 0);
    a = 1'b0;

    // STABLE_CYCLES=1 instance switches on the first qualifying edge
    check_eq("s1_idle", int'(sel1), 0);
    b1 = 1'b1;
    tick(); check_eq("s1_selb", int'(sel1), 1);
    b1 = 1'b0;
    tick(); check_eq("s1_holdb", int'(sel1), 1);
    a1 = 1'b1; b1 = 1'b1;
    tick(); check_eq("s1_tie", int'(sel1), 1);
    b1 = 1'b0;
    tick(); check_eq("s1_sela", int'(sel1), 0);
`ifdef FSM_01_STATE_OUT_EN
    check_eq("s1_st", int'(st1), 0);
    check_eq("s1_arm", int'(arm1), 0);
`endif
    a1 = 1'b0;
    tick(); check_eq("s1_holda", int'(sel1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
